clock_step_ctrl: RTL and testbench

//  Board-side front end for the pipelined processor. Debounces the raw step and

---
 rtl/clock_step_ctrl.sv | 177 +++++++++++++++++
 tb/tb_clock_step_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: board-side clock and reset front end for the pipelined processor.
// Debounces the step and reset pushbuttons, then issues either one clock pulse per
// step press or a free-running divided clock that parks low when the processor halts.
module clock_step_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20,
  parameter int PULSE_CYC = 4,
  parameter int RUN_DIV   = 2500000,
  parameter int DIV_W     = 22
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_step_n,
  input  logic        key_rst_n,
  input  logic        sw_run,
  input  logic        halt,
  output logic        cpu_clk,
  output logic        cpu_reset_n,
  output logic        running,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP_HI = 2'd1,
    RUN_LO  = 2'd2,
    RUN_HI  = 2'd3
  } state_t;

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [DIV_W-1:0] PULSE_LAST = DIV_W'(PULSE_CYC - 1);
  localparam logic [DIV_W-1:0] RUN_LAST   = DIV_W'(RUN_DIV - 1);

  logic [1:0]       step_sync;
  logic [1:0]       rst_sync;
  logic [1:0]       run_sync;
  logic [1:0]       halt_sync;

  logic [DB_W-1:0]  step_db_cnt;
  logic [DB_W-1:0]  rst_db_cnt;
  logic             step_stable;
  logic             rst_stable;
  logic             step_stable_d;
  logic             press_evt;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] ph;
  logic [DIV_W-1:0] ph_next;
  logic             phase_end;
  logic             clk_next;
  logic             running_next;
  logic             step_inc;
  logic [15:0]      count_next;

  // Two-flop synchronisers; keys and run switch idle high, halt idles low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_sync <= 2'b11;
      rst_sync  <= 2'b11;
      run_sync  <= 2'b11;
      halt_sync <= 2'b00;
    end else begin
      step_sync <= {step_sync[0], key_step_n};
      rst_sync  <= {rst_sync[0], key_rst_n};
      run_sync  <= {run_sync[0], sw_run};
      halt_sync <= {halt_sync[0], halt};
    end
  end

  // Step key debounce: accept a new level only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_db_cnt <= '0;
      step_stable <= 1'b1;
    end else if (step_sync[1] == step_stable) begin
      step_db_cnt <= '0;
    end else if (step_db_cnt == DB_LAST) begin
      step_stable <= step_sync[1];
      step_db_cnt <= '0;
    end else begin
      step_db_cnt <= step_db_cnt + DB_W'(1);
    end
  end

  // Reset key debounce, same filtering as the step key.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_db_cnt <= '0;
      rst_stable <= 1'b1;
    end else if (rst_sync[1] == rst_stable) begin
      rst_db_cnt <= '0;
    end else if (rst_db_cnt == DB_LAST) begin
      rst_stable <= rst_sync[1];
      rst_db_cnt <= '0;
    end else begin
      rst_db_cnt <= rst_db_cnt + DB_W'(1);
    end
  end

  // One-cycle press pulse the cycle after the debounced step key goes low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_stable_d <= 1'b1;
      press_evt     <= 1'b0;
    end else begin
      step_stable_d <= step_stable;
      press_evt     <= step_stable_d & ~step_stable;
    end
  end

  // State register; cpu_clk and running are flops loaded from the next-state decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ph      <= '0;
      cpu_clk <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      ph      <= ph_next;
      cpu_clk <= clk_next;
      running <= running_next;
    end
  end

  // Next-state logic; a held reset key overrides everything and parks the FSM in IDLE.
  always_comb begin
    state_next = state;
    phase_end  = (state == STEP_HI) ? (ph == PULSE_LAST) : (ph == RUN_LAST);
    if (!rst_stable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run_sync[1] && !halt_sync[1]) state_next = RUN_LO;
          else if (press_evt)               state_next = STEP_HI;
        end
        STEP_HI: begin
          if (phase_end) state_next = IDLE;
        end
        RUN_LO: begin
          if (phase_end) state_next = (halt_sync[1] || !run_sync[1]) ? IDLE : RUN_HI;
        end
        RUN_HI: begin
          if (phase_end) state_next = RUN_LO;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode: phase counter, clock level, run flag and edge-count update.
  always_comb begin
    if (state_next != state || state_next == IDLE) ph_next = '0;
    else                                           ph_next = ph + DIV_W'(1);
    clk_next     = (state_next == STEP_HI) || (state_next == RUN_HI);
    running_next = (state_next == RUN_LO) || (state_next == RUN_HI);
    step_inc     = ((state == IDLE) && (state_next == STEP_HI)) ||
                   ((state == RUN_LO) && (state_next == RUN_HI));
    count_next   = step_count;
    if (!rst_stable)                               count_next = '0;
    else if (step_inc && (step_count != 16'hFFFF)) count_next = step_count + 16'd1;
  end

  // Processor reset follows the debounced key; edge counter loads every cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_reset_n <= 1'b0;
      step_count  <= '0;
    end else begin
      cpu_reset_n <= rst_stable;
      step_count  <= count_next;
    end
  end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// tb_clock_step_ctrl: directed bench for clock_step_ctrl with small debounce and divider.
module tb_clock_step_ctrl;

  logic        clock;
  logic        reset;
  logic        key_step_n;
  logic        key_rst_n;
  logic        sw_run;
  logic        halt;
  logic        cpu_clk;
  logic        cpu_reset_n;
  logic        running;
  logic [15:0] step_count;

  int checks;
  int errors;
  int rise_cnt;
  int high_cnt;
  logic clk_prev;

  clock_step_ctrl #(
    .DB_CYCLES(4),
    .DB_W(3),
    .PULSE_CYC(2),
    .RUN_DIV(3),
    .DIV_W(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_step_n(key_step_n),
    .key_rst_n(key_rst_n),
    .sw_run(sw_run),
    .halt(halt),
    .cpu_clk(cpu_clk),
    .cpu_reset_n(cpu_reset_n),
    .running(running),
    .step_count(step_count)
  );

  // Board clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the sequence never reaches its end.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive inputs, then advance n edges sampling 1 time unit after each edge.
  task automatic applyStimulus(input logic step_n, input logic rst_n, input logic run,
                               input logic hlt, input int n);
    key_step_n = step_n;
    key_rst_n  = rst_n;
    sw_run     = run;
    halt       = hlt;
    repeat (n) begin
      @(posedge clock);
      #1;
      if (cpu_clk) high_cnt++;
      if (cpu_clk && !clk_prev) rise_cnt++;
      clk_prev = cpu_clk;
    end
  endtask

  task automatic clearMonitor();
    rise_cnt = 0;
    high_cnt = 0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rise_cnt   = 0;
    high_cnt   = 0;
    clk_prev   = 1'b0;
    reset      = 1'b1;
    key_step_n = 1'b1;
    key_rst_n  = 1'b1;
    sw_run     = 1'b0;
    halt       = 1'b0;

    // Power-on reset values
    #2;
    checkOutput("rst_cpu_clk", cpu_clk, 0);
    checkOutput("rst_cpu_reset_n", cpu_reset_n, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_step_count", step_count, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("rel_cpu_reset_n_before", cpu_reset_n, 0);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("rel_cpu_reset_n_after", cpu_reset_n, 1);
    applyStimulus(1, 1, 0, 0, 6);
    checkOutput("rel_running", running, 0);
    checkOutput("rel_cpu_clk", cpu_clk, 0);

    // Bouncy step key: short lows are filtered, the long hold gives one 2-cycle pulse
    clearMonitor();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 0, 2);
      applyStimulus(1, 1, 0, 0, 2);
    end
    checkOutput("bounce_no_early_pulse", rise_cnt, 0);
    applyStimulus(0, 1, 0, 0, 10);
    applyStimulus(1, 1, 0, 0, 10);
    checkOutput("bounce_rises", rise_cnt, 1);
    checkOutput("bounce_high_cycles", high_cnt, 2);
    checkOutput("bounce_step_count", step_count, 1);

    // Clean press: high after edge 8, low after edge 10
    applyStimulus(0, 1, 0, 0, 7);
    checkOutput("lat_edge7", cpu_clk, 0);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("lat_edge8", cpu_clk, 1);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("lat_edge9", cpu_clk, 1);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("lat_edge10", cpu_clk, 0);
    applyStimulus(1, 1, 0, 0, 10);
    checkOutput("lat_step_count", step_count, 2);

    // Three-cycle glitch is shorter than the debounce window
    clearMonitor();
    applyStimulus(0, 1, 0, 0, 3);
    applyStimulus(1, 1, 0, 0, 12);
    checkOutput("glitch_rises", rise_cnt, 0);
    checkOutput("glitch_step_count", step_count, 2);

    // Run mode for 60 cycles: RUN_LO from edge 3, rising edges at 6,12,...,60
    clearMonitor();
    applyStimulus(1, 1, 1, 0, 60);
    checkOutput("run_rises", rise_cnt, 10);
    checkOutput("run_high_cycles", high_cnt, 28);
    checkOutput("run_running", running, 1);
    checkOutput("run_cpu_clk", cpu_clk, 1);
    checkOutput("run_step_count", step_count, 12);

    // Halt raised at the start of a high phase: finish high, finish low, park
    applyStimulus(1, 1, 1, 1, 2);
    checkOutput("halt_high_kept", cpu_clk, 1);
    applyStimulus(1, 1, 1, 1, 1);
    checkOutput("halt_low_phase", cpu_clk, 0);
    checkOutput("halt_low_running", running, 1);
    applyStimulus(1, 1, 1, 1, 3);
    checkOutput("halt_parked_running", running, 0);
    clearMonitor();
    applyStimulus(1, 1, 1, 1, 20);
    checkOutput("halt_frozen_rises", rise_cnt, 0);
    checkOutput("halt_frozen_count", step_count, 12);
    applyStimulus(0, 1, 1, 1, 10);
    applyStimulus(1, 1, 1, 1, 10);
    checkOutput("halt_step_rises", rise_cnt, 1);
    checkOutput("halt_step_high", high_cnt, 2);
    checkOutput("halt_step_count", step_count, 13);

    // Reset key lands during a high phase and cuts it short
    applyStimulus(1, 1, 1, 0, 6);
    checkOutput("rkey_run_hi", cpu_clk, 1);
    checkOutput("rkey_count_a", step_count, 14);
    applyStimulus(1, 0, 1, 0, 6);
    checkOutput("rkey_second_hi", cpu_clk, 1);
    checkOutput("rkey_count_b", step_count, 15);
    checkOutput("rkey_not_yet", cpu_reset_n, 1);
    applyStimulus(1, 1, 1, 0, 1);
    checkOutput("rkey_cpu_reset_n", cpu_reset_n, 0);
    checkOutput("rkey_cpu_clk", cpu_clk, 0);
    checkOutput("rkey_running", running, 0);
    checkOutput("rkey_count_clr", step_count, 0);
    applyStimulus(1, 1, 1, 0, 5);
    checkOutput("rkey_held_n", cpu_reset_n, 0);
    applyStimulus(1, 1, 1, 0, 1);
    checkOutput("rkey_released_n", cpu_reset_n, 1);
    checkOutput("rkey_resume_running", running, 1);

    // Leave run mode, then check saturation from a preloaded FFFF
    applyStimulus(1, 1, 0, 0, 12);
    checkOutput("stop_running", running, 0);
    checkOutput("stop_count", step_count, 0);
    force dut.step_count = 16'hFFFF;
    applyStimulus(1, 1, 0, 0, 1);
    release dut.step_count;
    applyStimulus(1, 1, 0, 0, 2);
    checkOutput("sat_preload", step_count, 16'hFFFF);
    clearMonitor();
    applyStimulus(0, 1, 0, 0, 10);
    applyStimulus(1, 1, 0, 0, 10);
    checkOutput("sat_rises", rise_cnt, 1);
    checkOutput("sat_hold", step_count, 16'hFFFF);

    // Asynchronous reset asserted during a run-mode high phase
    applyStimulus(1, 1, 1, 0, 7);
    checkOutput("mid_pre_clk", cpu_clk, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_cpu_clk", cpu_clk, 0);
    checkOutput("mid_cpu_reset_n", cpu_reset_n, 0);
    checkOutput("mid_running", running, 0);
    checkOutput("mid_step_count", step_count, 0);
    applyStimulus(1, 1, 0, 0, 2);
    reset = 1'b0;
    checkOutput("mid_rel_before", cpu_reset_n, 0);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("mid_rel_after", cpu_reset_n, 1);
    checkOutput("mid_rel_clk", cpu_clk, 0);
    clearMonitor();
    applyStimulus(1, 1, 0, 0, 8);
    checkOutput("mid_idle_running", running, 0);
    checkOutput("mid_idle_rises", rise_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
